ddr_tx_framer: RTL and testbench

Transmit framer that feeds `x_mux_ddr` on the 80 MHz output links. It buffers 4×WIDTH-bit transmit words in a small FIFO and emits each word as two consecutive 40 MHz frames. Each frame is split into `din1st`/`din2nd` slices that the DDR mux serializes. Between words it drives a fixed idle pattern and holds the output drivers off until a startup delay has expired.

---
 rtl/ddr_tx_framer.sv | 152 +++++++++++++++
 tb/tb_ddr_tx_framer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_framer.sv
// Transmit framer for the DDR output mux: queues 4*WIDTH-bit words and emits each
// word as two consecutive frames of din1st/din2nd slices, idling with drivers off.
module ddr_tx_framer #(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] IDLE_PAT   = {WIDTH{1'b0}},
    parameter int unsigned      STARTUP    = 8
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [4*WIDTH-1:0] wr_data,
    output logic               wr_full,
    input  logic               clr_err,
    output logic               overflow,
    output logic [WIDTH-1:0]   din1st,
    output logic [WIDTH-1:0]   din2nd,
    output logic               noe,
    output logic               tx_frame,
    output logic               tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARTUP + 1);
    localparam int unsigned DW = 4 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_F0, S_F1} state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            rd_ok;
    logic [SW-1:0]   st_cnt;
    logic            ready;
    logic            push;
    logic            pop;
    logic [DW-1:0]   head_word;
    logic [DW-1:0]   word_q;

    assign push       = wr_en & ~wr_full;
    assign count_next = count + CW'(push) - CW'(pop);
    assign head_word  = mem[rd_ptr];
    assign ready      = (st_cnt == SW'(STARTUP));

    // FIFO storage; contents need no reset, emptiness is held by the pointers
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // rd_ok: head word has been resident for at least one full edge
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_full <= 1'b0;
            rd_ok   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            wr_full <= (count_next == CW'(FIFO_DEPTH));
            rd_ok   <= (count_next > CW'(1)) | ((count_next == CW'(1)) & ~push);
        end
    end

    // Sticky overflow; a dropped write beats a same-cycle clear
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            overflow <= 1'b0;
        end else if (wr_en && wr_full) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

    // Startup delay counter, saturating at STARTUP
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            st_cnt <= '0;
        end else if (!ready) begin
            st_cnt <= st_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (ready && enable && rd_ok) begin
                    pop        = 1'b1;
                    state_next = S_F0;
                end
            end
            S_F0: state_next = S_F1;
            S_F1: begin
                if (enable && rd_ok) begin
                    pop        = 1'b1;
                    state_next = S_F0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output registers track the next state; frame1 comes from the held word
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            word_q   <= '0;
            din1st   <= IDLE_PAT;
            din2nd   <= IDLE_PAT;
            noe      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_frame <= 1'b0;
        end else begin
            if (pop) word_q <= head_word;
            case (state_next)
                S_F0: begin
                    din1st <= head_word[WIDTH-1:0];
                    din2nd <= head_word[2*WIDTH-1:WIDTH];
                end
                S_F1: begin
                    din1st <= word_q[3*WIDTH-1:2*WIDTH];
                    din2nd <= word_q[4*WIDTH-1:3*WIDTH];
                end
                default: begin
                    din1st <= IDLE_PAT;
                    din2nd <= IDLE_PAT;
                end
            endcase
            noe      <= ~((state_next != S_IDLE) | (ready & enable));
            tx_busy  <= (state_next != S_IDLE);
            tx_frame <= (state_next == S_F1);
        end
    end

endmodule

// File: tb/tb_ddr_tx_framer.sv
// Bench for ddr_tx_framer: directed scenarios plus random traffic, compared each
// edge against a queue-based model of word timing.
module tb_ddr_tx_framer;

    localparam int unsigned W       = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned STARTUP = 8;

    logic           clock   = 1'b0;
    logic           aclr    = 1'b1;
    logic           enable  = 1'b0;
    logic           wr_en   = 1'b0;
    logic [4*W-1:0] wr_data = '0;
    logic           clr_err = 1'b0;
    logic           wr_full;
    logic           overflow;
    logic [W-1:0]   din1st;
    logic [W-1:0]   din2nd;
    logic           noe;
    logic           tx_frame;
    logic           tx_busy;

    always #5 clock = ~clock;

    ddr_tx_framer #(
        .WIDTH(W), .FIFO_DEPTH(DEPTH), .IDLE_PAT(16'h0000), .STARTUP(STARTUP)
    ) dut (
        .clock(clock), .aclr(aclr), .enable(enable), .wr_en(wr_en),
        .wr_data(wr_data), .wr_full(wr_full), .clr_err(clr_err),
        .overflow(overflow), .din1st(din1st), .din2nd(din2nd), .noe(noe),
        .tx_frame(tx_frame), .tx_busy(tx_busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model: queue of words with the edge each was written; cur is the frame on
    // the outputs (-1 idle, 0 frame0, 1 frame1); sc counts edges since release.
    logic [63:0] q_data[$];
    int          q_edge[$];
    int          cyc, cur, sc;
    logic [63:0] m_word;
    logic        m_ovf, e_noe, e_busy, e_frame, e_full;
    logic [15:0] e_d1, e_d2;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        q_data.delete();
        q_edge.delete();
        cyc = 0; cur = -1; sc = 0; m_ovf = 1'b0; m_word = '0;
        e_d1 = '0; e_d2 = '0; e_noe = 1'b1; e_busy = 1'b0; e_frame = 1'b0; e_full = 1'b0;
    endtask

    task automatic model_step(logic en, logic we, logic [63:0] wd, logic clr);
        bit rdy, full_b, head_ok;
        int nxt;
        cyc++;
        rdy    = (sc == STARTUP);
        full_b = (q_data.size() == DEPTH);
        head_ok = 1'b0;
        if (q_data.size() > 0) head_ok = (q_edge[0] <= cyc - 2);
        if (cur == 0) nxt = 1;
        else if (en && head_ok && (cur == 1 || rdy)) begin
            nxt = 0;
            m_word = q_data.pop_front();
            void'(q_edge.pop_front());
        end else nxt = -1;
        if (we && !full_b) begin
            q_data.push_back(wd);
            q_edge.push_back(cyc);
        end
        if (we && full_b) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        cur = nxt;
        if (nxt == 0)      begin e_d1 = m_word[15:0];  e_d2 = m_word[31:16]; end
        else if (nxt == 1) begin e_d1 = m_word[47:32]; e_d2 = m_word[63:48]; end
        else               begin e_d1 = '0;            e_d2 = '0;            end
        e_busy  = (nxt != -1);
        e_frame = (nxt == 1);
        e_noe   = !((nxt != -1) || (rdy && en));
        e_full  = (q_data.size() == DEPTH);
        if (sc < STARTUP) sc++;
    endtask

    task automatic check_all();
        chk("din1st",   64'(din1st),   64'(e_d1));
        chk("din2nd",   64'(din2nd),   64'(e_d2));
        chk("noe",      64'(noe),      64'(e_noe));
        chk("tx_busy",  64'(tx_busy),  64'(e_busy));
        chk("tx_frame", 64'(tx_frame), 64'(e_frame));
        chk("wr_full",  64'(wr_full),  64'(e_full));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic tick(logic rel, logic en, logic we, logic [63:0] wd, logic clr);
        @(negedge clock);
        if (rel) aclr = 1'b0;
        enable = en; wr_en = we; wr_data = wd; clr_err = clr;
        @(posedge clock);
        model_step(en, we, wd, clr);
        #1;
        check_all();
    endtask

    initial begin
        logic [63:0] wa, wb, wc;
        model_reset();
        enable = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_all();

        // Startup delay: drivers stay off through edge STARTUP, on at the next
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (STARTUP - 1) tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("noe_startup_off", 64'(noe), 64'd1);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("noe_startup_on", 64'(noe), 64'd0);
        chk("idle_pat", 64'(din1st), 64'd0);

        // Single word latency
        tick(1'b0, 1'b1, 1'b1, 64'h4444_3333_2222_1111, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("k2_din1st", 64'(din1st), 64'h1111);
        chk("k2_din2nd", 64'(din2nd), 64'h2222);
        chk("k2_frame",  64'(tx_frame), 64'd0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("k3_din1st", 64'(din1st), 64'h3333);
        chk("k3_din2nd", 64'(din2nd), 64'h4444);
        chk("k3_frame",  64'(tx_frame), 64'd1);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("k4_idle", 64'({din2nd, din1st}), 64'd0);

        // Fill while disabled, overflow, then stream eight frames
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
        chk("full_after_4", 64'(wr_full), 64'd1);
        tick(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        chk("overflow_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
            chk("stream_busy", 64'(tx_busy), 64'd1);
        end
        tick(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("overflow_clr", 64'(overflow), 64'd0);
        chk("stream_end", 64'(tx_busy), 64'd0);

        // enable dropped during F0 with two words queued
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        tick(1'b0, 1'b0, 1'b1, wa, 1'b0);
        tick(1'b0, 1'b0, 1'b1, wb, 1'b0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("drop_f1_noe", 64'(noe), 64'd0);
        chk("drop_f1_frame", 64'(tx_frame), 64'd1);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("drop_idle_noe", 64'(noe), 64'd1);
        chk("drop_idle_busy", 64'(tx_busy), 64'd0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("reenable_word", 64'(din1st), 64'(wb[15:0]));
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // aclr during F1 with a word still queued
        wc = {$urandom, $urandom};
        tick(1'b0, 1'b1, 1'b1, wc, 1'b0);
        tick(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("pre_abort_f1", 64'(tx_frame), 64'd1);
        #2 aclr = 1'b1;
        #1;
        chk("abort_noe",  64'(noe), 64'd1);
        chk("abort_busy", 64'(tx_busy), 64'd0);
        chk("abort_data", 64'({din2nd, din1st}), 64'd0);
        chk("abort_full", 64'(wr_full), 64'd0);
        model_reset();
        repeat (2) @(posedge clock);
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, ($urandom_range(0, 99) < 85), $urandom_range(0, 1) == 1,
                 {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
